// File: rtl/irq_pkg.sv
// Shared constants and helpers for the interrupt aggregator.
package irq_pkg;

  // Source index map on the interrupt register
  localparam int IRQ_PCM_INT0   = 0;
  localparam int IRQ_PCM_INT1   = 1;
  localparam int IRQ_DAC_ZERO_R = 2;
  localparam int IRQ_DAC_ZERO_L = 3;
  localparam int IRQ_PWR        = 7;

  // Defaults for the 8-source build: everything edge-captured, all masked
  localparam int         IRQ_NUM_SRC_DEF = 8;
  localparam logic [7:0] EDGE_MASK_DEF   = 8'hFF;
  localparam logic [7:0] MASK_RESET_DEF  = 8'h00;

  // Width of the stability counter: ceil(log2(cycles+1)), never below 1 bit
  function automatic int filt_cnt_w(input int cycles);
    if (cycles < 1) return 1;
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/irq_input_filter.sv
// One interrupt source: synchroniser, glitch filter and rising-edge detect.
module irq_input_filter
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,  // at least 2
  parameter int FILTER_CYCLES = 4   // 0 bypasses the filter
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic src_i,
  output logic filt_o,
  output logic rise_o
);

  localparam int CW = filt_cnt_w(FILTER_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   filt_q, filt_d;
  logic                   filt_prev_q;
  logic [CW-1:0]          cnt_q, cnt_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; bit 0 takes the raw asynchronous input
  always_ff @(posedge clk_i) begin
    if (reset_i) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
  end

  generate
    if (FILTER_CYCLES == 0) begin : g_nofilt
      // No filtering: the filtered value follows the synchroniser directly
      always_comb begin
        filt_d = sync;
        cnt_d  = '0;
      end
    end else begin : g_filt
      // Count consecutive cycles the synchronised value disagrees with
      // filt_q; adopt it only after FILTER_CYCLES of uninterrupted disagreement
      always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync != filt_q) begin
          if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
            filt_d = sync;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    end
  endgenerate

  // Filter state and the one-cycle-delayed copy used for edge detect
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      cnt_q       <= cnt_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = filt_q & ~filt_prev_q;

endmodule

// File: rtl/irq_aggregator.sv
// Interrupt aggregator: per-source filter/capture, enable mask, single irq.
module irq_aggregator
  import irq_pkg::*;
#(
  parameter int                 NUM_SRC       = IRQ_NUM_SRC_DEF,
  parameter int                 SYNC_STAGES   = 2,
  parameter int                 FILTER_CYCLES = 4,
  parameter logic [NUM_SRC-1:0] EDGE_MASK     = NUM_SRC'(EDGE_MASK_DEF),
  parameter logic [NUM_SRC-1:0] MASK_RESET    = NUM_SRC'(MASK_RESET_DEF)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_SRC-1:0] src_in_i,
  input  logic               mask_wr_stb_i,
  input  logic [NUM_SRC-1:0] mask_wr_data_i,
  input  logic               rd_stb_i,
  output logic [NUM_SRC-1:0] mask_o,
  output logic [NUM_SRC-1:0] pending_o,
  output logic [NUM_SRC-1:0] overrun_o,
  output logic               irq_o
);

  logic [NUM_SRC-1:0] filt, rise;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] overrun_q, overrun_d;
  logic               irq_q, irq_d;

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      irq_input_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
      ) u_filt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .src_i  (src_in_i[i]),
        .filt_o (filt[i]),
        .rise_o (rise[i])
      );
    end
  endgenerate

  // Capture: edge sources are sticky until read, and a rise arriving in the
  // read cycle re-sets the bit so the event is not lost. Overrun records a
  // second rise on an already-pending bit; in the read cycle that rise just
  // becomes the new pending event instead. Level sources mirror filt.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (EDGE_MASK[i]) begin
        if (rd_stb_i) begin
          pending_d[i] = rise[i];
          overrun_d[i] = 1'b0;
        end else begin
          pending_d[i] = pending_q[i] | rise[i];
          overrun_d[i] = overrun_q[i] | (rise[i] & pending_q[i]);
        end
      end else begin
        pending_d[i] = filt[i];
        overrun_d[i] = 1'b0;
      end
    end
  end

  // Mask register write and irq generation; masking gates only the irq
  always_comb begin
    mask_d = mask_wr_stb_i ? mask_wr_data_i : mask_q;
    irq_d  = |(pending_q & mask_q);
  end

  // Status, mask and irq registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mask_q    <= MASK_RESET;
      pending_q <= '0;
      overrun_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      irq_q     <= irq_d;
    end
  end

  assign mask_o    = mask_q;
  assign pending_o = pending_q;
  assign overrun_o = overrun_q;
  assign irq_o     = irq_q;

endmodule
